// File: rtl/image_padding_ctrl_if.sv
// Bundle of the padding sequencer's configuration, FIFO read side and padded output stream.
// Optional feature macro: PAD_VALUE_EN adds pad_value (programmable pad word).
interface image_padding_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 11,
  parameter int PAD_BITS  = 2
);
  logic                 start;
  logic [ADDR_BITS-1:0] row_len;
  logic [ADDR_BITS-1:0] row_num;
  logic [PAD_BITS-1:0]  pad;
`ifdef PAD_VALUE_EN
  logic [WIDTH-1:0]     pad_value;
`endif
  logic                 fifo_valid;
  logic [WIDTH-1:0]     fifo_dout;
  logic                 fifo_rd_en;
  logic [ADDR_BITS-1:0] m_count;
  logic [WIDTH-1:0]     m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 busy;
  logic                 done;

`ifdef PAD_VALUE_EN
  modport master (
    input  start, row_len, row_num, pad, pad_value, fifo_valid, fifo_dout, m_ready,
    output fifo_rd_en, m_count, m_data, m_valid, busy, done
  );
  modport slave (
    output start, row_len, row_num, pad, pad_value, fifo_valid, fifo_dout, m_ready,
    input  fifo_rd_en, m_count, m_data, m_valid, busy, done
  );
`else
  modport master (
    input  start, row_len, row_num, pad, fifo_valid, fifo_dout, m_ready,
    output fifo_rd_en, m_count, m_data, m_valid, busy, done
  );
  modport slave (
    output start, row_len, row_num, pad, fifo_valid, fifo_dout, m_ready,
    input  fifo_rd_en, m_count, m_data, m_valid, busy, done
  );
`endif
endinterface

// File: rtl/image_padding_ctrl.sv
// Padding sequencer: reads rows from the padding FIFO and emits a frame with a pad border.
// Optional feature macro: PAD_VALUE_EN selects a latched pad_value as the pad word (else zero).
module image_padding_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 11,
  parameter int PAD_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  image_padding_ctrl_if.master bus
);
  localparam int CW = ADDR_BITS + PAD_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TOP, S_WAIT, S_LEFT, S_DATA, S_RIGHT, S_BOT, S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] len_q, num_q;
  logic [PAD_BITS-1:0]  pad_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]        row_q, row_d;
  logic                 inflight_q;
  logic [1:0]           ho_q, ho_d;
  logic [1:0]           occ_q, occ_d, occ_after_pop;
  logic [WIDTH-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]     pad_word;
  logic [CW-1:0]        row_w, top_n, seg_target;
  logic                 pad_state, pad_push, rd_en, pop, push, seg_end;
  logic [WIDTH-1:0]     push_data;

`ifdef PAD_VALUE_EN
  logic [WIDTH-1:0] padval_q;
  // Pad word captured at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) padval_q <= '0;
    else if (state_q == S_IDLE && bus.start) padval_q <= bus.pad_value;
  end
  assign pad_word = padval_q;
`else
  assign pad_word = '0;
`endif

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_count    = len_q;
  assign bus.m_data     = buf0_q;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Datapath: read issue, pad push, 2-entry in-order output buffer, row holdoff
  always_comb begin
    row_w         = CW'(len_q) + (CW'(pad_q) << 1);
    top_n         = CW'(pad_q) * row_w;
    pad_state     = (state_q == S_TOP) || (state_q == S_LEFT) ||
                    (state_q == S_RIGHT) || (state_q == S_BOT);
    seg_target    = (state_q == S_TOP || state_q == S_BOT) ? top_n : CW'(pad_q);
    pop           = (occ_q != 2'd0) && bus.m_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    pad_push      = pad_state && (cnt_q != seg_target) && (occ_after_pop < 2'd2);
    // Reads in flight reserve a slot so a landing can never overflow the buffer
    rd_en         = (state_q == S_DATA) && (rd_cnt_q < CW'(len_q)) &&
                    (({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
    push          = pad_push || inflight_q;
    push_data     = inflight_q ? bus.fifo_dout : pad_word;
    seg_end       = pad_state && ((cnt_q == seg_target) ||
                    (pad_push && (cnt_q + CW'(1) == seg_target)));

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) buf0_d = buf1_q;
    if (push) begin
      if (occ_after_pop == 2'd0) buf0_d = push_data;
      else                       buf1_d = push_data;
    end
    occ_d = occ_after_pop + {1'b0, push};

    // fifo_valid lags the FIFO count, so mask it after a row's final read
    ho_d = (ho_q != 2'd0) ? ho_q - 2'd1 : 2'd0;
    if (rd_en && (rd_cnt_q + CW'(1) == CW'(len_q))) ho_d = 2'd2;
  end

  // Next-state logic for the frame sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(pad_push);
    rd_cnt_d = rd_cnt_q + CW'(rd_en);
    row_d    = row_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          row_d  = '0;
          if (bus.row_len == '0 || bus.row_num == '0) state_d = S_FIN;
          else if (bus.pad == '0)                     state_d = S_WAIT;
          else                                         state_d = S_TOP;
        end
      end
      S_TOP: begin
        if (seg_end) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rd_cnt_d = '0;
        if (bus.fifo_valid && ho_q == 2'd0) begin
          cnt_d   = '0;
          state_d = S_LEFT;
        end
      end
      S_LEFT: begin
        if (seg_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = '0;
        if (rd_cnt_q == CW'(len_q) && !inflight_q) state_d = S_RIGHT;
      end
      S_RIGHT: begin
        if (seg_end) begin
          cnt_d = '0;
          row_d = row_q + CW'(1);
          if (row_q + CW'(1) < CW'(num_q)) state_d = S_WAIT;
          else if (pad_q == '0)            state_d = S_FIN;
          else                             state_d = S_BOT;
        end
      end
      S_BOT: begin
        if (seg_end) state_d = S_FIN;
      end
      S_FIN: begin
        if (occ_q == 2'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, buffer and frame configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      num_q      <= '0;
      pad_q      <= '0;
      cnt_q      <= '0;
      rd_cnt_q   <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      ho_q       <= '0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      row_q      <= row_d;
      inflight_q <= rd_en;
      ho_q       <= ho_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (state_q == S_IDLE && bus.start) begin
        len_q <= bus.row_len;
        num_q <= bus.row_num;
        pad_q <= bus.pad;
      end
    end
  end
endmodule

// File: tb/tb_image_padding_ctrl.sv
// Directed bench for image_padding_ctrl with a behavioural FIFO on the read side.
module tb_image_padding_ctrl;
  localparam int WIDTH = 8;
  localparam int AB    = 11;
  localparam int PB    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  image_padding_ctrl_if #(.WIDTH(WIDTH), .ADDR_BITS(AB), .PAD_BITS(PB)) bus ();
  image_padding_ctrl #(.WIDTH(WIDTH), .ADDR_BITS(AB), .PAD_BITS(PB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] feed_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         runs_q[$];
  logic [7:0] pw;
  int cur_len, n_done, stall_bad, rd_empty, early, timeout;

  // Standard FIFO model: count-based valid is registered (one cycle behind occupancy)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q.delete();
      bus.fifo_valid <= 1'b0;
      bus.fifo_dout  <= '0;
    end else begin
      bus.fifo_valid <= (fifo_q.size() >= int'(bus.m_count));
      if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
    end
  end

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
  endtask

  function automatic void build_exp(input int len, input int num, input int pd, input logic [7:0] base);
    exp_q.delete();
    for (int r = 0; r < num + 2 * pd; r++)
      for (int c = 0; c < len + 2 * pd; c++)
        if (r < pd || r >= pd + num || c < pd || c >= pd + len) exp_q.push_back(pw);
        else exp_q.push_back(base + 8'((r - pd) * len + (c - pd)));
  endfunction

  task automatic do_start(input int len, input int num, input int pd, input logic [7:0] pv);
    @(negedge clk);
    bus.row_len = AB'(len);
    bus.row_num = AB'(num);
    bus.pad     = PB'(pd);
`ifdef PAD_VALUE_EN
    bus.pad_value = pv;
    pw = pv;
`else
    pw = 8'h00;
`endif
    bus.m_ready = 1'b1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Drives m_ready / slow feed, records transfers and read-side statistics until done
  task automatic run_frame(input int maxc, input bit rnd, input int busy_at);
    logic       prev_stall;
    logic [7:0] prev_data;
    int         after, cur_run, rd_total;
    got_q.delete(); runs_q.delete();
    n_done = 0; stall_bad = 0; rd_empty = 0; early = 0; timeout = 0;
    prev_stall = 1'b0; prev_data = '0; after = -1; cur_run = 0; rd_total = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (feed_q.size() > 0 && c % 4 == 0) fifo_q.push_back(feed_q.pop_front());
      bus.start = (c == busy_at);
      if (c == busy_at) begin
        bus.row_len = AB'(2); bus.row_num = AB'(1); bus.pad = '0;
      end
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data)) stall_bad++;
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      if (bus.fifo_rd_en) begin
        if (fifo_q.size() == 0) rd_empty++;
        if (cur_len > 0 && rd_total % cur_len == 0 && fifo_q.size() < cur_len) early++;
        rd_total++;
        cur_run++;
      end else if (cur_run > 0) begin
        runs_q.push_back(cur_run);
        cur_run = 0;
      end
      if (bus.done) begin
        n_done++;
        if (after < 0) after = 4;
      end
      if (after > 0) after--;
      else if (after == 0) break;
    end
    if (cur_run > 0) runs_q.push_back(cur_run);
    if (after < 0) timeout = 1;
    bus.start   = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.row_len = '0; bus.row_num = '0; bus.pad = '0; bus.m_ready = 1'b1;
`ifdef PAD_VALUE_EN
    bus.pad_value = '0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", bus.m_data); end
    n_cmp++; if (bus.m_count !== 11'd0) begin n_fail++; $display("FAIL reset_m_count: got %0d expected 0", bus.m_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill(8'd1, 12);
    cur_len = 4;
    do_start(4, 3, 1, 8'h00);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    n_cmp++; if (bus.m_count !== 11'd4) begin n_fail++; $display("FAIL basic_m_count: got %0d expected 4", bus.m_count); end
    run_frame(400, 1'b0, -1);
    build_exp(4, 3, 1, 8'd1);
    n_cmp++; if (timeout !== 0) begin n_fail++; $display("FAIL basic_timeout: got done=%0d expected 1", n_done); end
    n_cmp++; if (got_q.size() !== 30) begin n_fail++; $display("FAIL basic_count: got %0d expected 30", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", n_done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    fill(8'd1, 12);
    cur_len = 4;
    do_start(4, 3, 1, 8'h00);
    run_frame(800, 1'b1, -1);
    build_exp(4, 3, 1, 8'd1);
    n_cmp++; if (got_q.size() !== 30) begin n_fail++; $display("FAIL bp_count: got %0d expected 30", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_hold: got %0d changes expected 0", stall_bad); end
    n_cmp++; if (rd_empty !== 0) begin n_fail++; $display("FAIL bp_rd_empty: got %0d expected 0", rd_empty); end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", n_done); end
  endtask

  task automatic test_nopad();
    fill(8'hA0, 16);
    cur_len = 8;
    do_start(8, 2, 0, 8'h00);
    run_frame(400, 1'b0, -1);
    build_exp(8, 2, 0, 8'hA0);
    n_cmp++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL nopad_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nopad_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (runs_q.size() !== 2) begin n_fail++; $display("FAIL nopad_runs: got %0d bursts expected 2", runs_q.size()); end
    for (int i = 0; i < runs_q.size(); i++) begin
      n_cmp++;
      if (runs_q[i] !== 8) begin n_fail++; $display("FAIL nopad_burst[%0d]: got %0d expected 8", i, runs_q[i]); end
    end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL nopad_done_pulses: got %0d expected 1", n_done); end
  endtask

  task automatic test_slow_fill();
    for (int i = 0; i < 8; i++) feed_q.push_back(8'h40 + 8'(i));
    cur_len = 4;
    do_start(4, 2, 1, 8'h00);
    run_frame(600, 1'b0, -1);
    build_exp(4, 2, 1, 8'h40);
    n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL slow_early_read: got %0d expected 0", early); end
    n_cmp++; if (rd_empty !== 0) begin n_fail++; $display("FAIL slow_rd_empty: got %0d expected 0", rd_empty); end
    n_cmp++; if (got_q.size() !== 24) begin n_fail++; $display("FAIL slow_count: got %0d expected 24", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL slow_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL slow_done_pulses: got %0d expected 1", n_done); end
  endtask

  task automatic test_start_busy_and_empty();
    fill(8'd1, 12);
    cur_len = 4;
    do_start(4, 3, 1, 8'h00);
    run_frame(400, 1'b0, 10);
    build_exp(4, 3, 1, 8'd1);
    n_cmp++; if (got_q.size() !== 30) begin n_fail++; $display("FAIL busystart_count: got %0d expected 30", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busystart_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL busystart_done_pulses: got %0d expected 1", n_done); end
    n_cmp++; if (bus.m_count !== 11'd4) begin n_fail++; $display("FAIL busystart_m_count: got %0d expected 4", bus.m_count); end
    // Empty frame: done two cycles after the start cycle, nothing read or emitted
    do_start(4, 0, 1, 8'h00);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL empty_cycle1: got done=%b busy=%b expected done=0 busy=1", bus.done, bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL empty_cycle2: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
    n_cmp++; if (bus.m_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL empty_activity: got m_valid=%b rd_en=%b expected 0 0", bus.m_valid, bus.fifo_rd_en); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL empty_done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_reset_mid();
    int waited;
    fill(8'd1, 12);
    cur_len = 4;
    do_start(4, 3, 1, 8'h00);
    waited = 0;
    while (bus.fifo_rd_en !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL midrst_reach_data: got rd_en=%b expected 1 within 100 cycles", bus.fifo_rd_en); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00)
      begin n_fail++; $display("FAIL midrst_outputs: got rd_en=%b m_valid=%b m_data=%h expected 0 0 00", bus.fifo_rd_en, bus.m_valid, bus.m_data); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.m_count !== 11'd0)
      begin n_fail++; $display("FAIL midrst_status: got busy=%b done=%b m_count=%0d expected 0 0 0", bus.busy, bus.done, bus.m_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(8'h10, 12);
    do_start(4, 3, 1, 8'h80);
    run_frame(400, 1'b0, -1);
    build_exp(4, 3, 1, 8'h10);
    n_cmp++; if (got_q.size() !== 30) begin n_fail++; $display("FAIL postrst_count: got %0d expected 30", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL postrst_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL postrst_done_pulses: got %0d expected 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_nopad();
    test_slow_fill();
    test_start_busy_and_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
